// File: rtl/fetch_pkg.sv
// rtl/fetch_pkg.sv - shared types and constants for the instruction-fetch stage
package fetch_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_EXEC  = 2'd2,
        ST_HALT  = 2'd3
    } fetch_state_t;

    // Same 2-bit encoding the main decoder drives on BranchType
    localparam logic [1:0] BT_BEQ  = 2'b00;
    localparam logic [1:0] BT_BGEZ = 2'b01;
    localparam logic [1:0] BT_BGT  = 2'b10;
    localparam logic [1:0] BT_BNEZ = 2'b11;

    localparam logic [31:0] PC_RESET_DEFAULT = 32'h0000_0000;

    function automatic logic [31:0] branch_offset(input logic [15:0] imm);
        return {{14{imm[15]}}, imm, 2'b00};
    endfunction

endpackage

// File: rtl/fetch_unit_branch_resolve.sv
// rtl/fetch_unit_branch_resolve.sv - combinational taken evaluation and next-PC select
module branch_resolve
    import fetch_pkg::*;
(
    input  logic [31:0] i_pc_plus4,
    input  logic [25:0] i_instr_idx,
    input  logic        i_branch,
    input  logic        i_jump,
    input  logic [1:0]  i_branch_type,
    input  logic        i_alu_zero,
    input  logic        i_alu_neg,
    input  logic        i_rs_neg,
    output logic [31:0] o_next_pc
);

    logic        w_cond;
    logic [31:0] w_jump_pc;
    logic [31:0] w_branch_pc;

    always_comb begin
        w_cond = 1'b0;
        case (i_branch_type)
            BT_BEQ:  w_cond = i_alu_zero;
            BT_BGEZ: w_cond = !i_rs_neg;
            BT_BGT:  w_cond = !i_alu_zero && !i_alu_neg;
            BT_BNEZ: w_cond = !i_alu_zero;
            default: w_cond = 1'b0;
        endcase
    end

    assign w_jump_pc   = {i_pc_plus4[31:28], i_instr_idx, 2'b00};
    assign w_branch_pc = i_pc_plus4 + branch_offset(i_instr_idx[15:0]);

    // Jump outranks a simultaneously asserted branch
    always_comb begin
        o_next_pc = i_pc_plus4;
        if (i_jump) begin
            o_next_pc = w_jump_pc;
        end else if (i_branch && w_cond) begin
            o_next_pc = w_branch_pc;
        end
    end

endmodule

// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - PC sequencing and instruction fetch FSM feeding the main decoder
module fetch_unit
    import fetch_pkg::*;
#(
    parameter logic [31:0] PC_RESET = PC_RESET_DEFAULT,
    parameter int unsigned TIMEOUT  = 16
) (
    input  logic        clk_i,
    input  logic        rst_i,
    output logic        imem_req_o,
    output logic [31:0] imem_addr_o,
    input  logic        imem_rvalid_i,
    input  logic [31:0] imem_rdata_i,
    output logic [31:0] instr_o,
    output logic        instr_valid_o,
    output logic [31:0] pc_o,
    output logic [31:0] pc_plus4_o,
    input  logic        branch_i,
    input  logic        jump_i,
    input  logic [1:0]  branch_type_i,
    input  logic        alu_zero_i,
    input  logic [31:0] alu_result_i,
    input  logic [31:0] rs_data_i,
    input  logic        stall_i,
    output logic [31:0] retire_cnt_o,
    output logic        fetch_err_o
);

    localparam int WAIT_W = $clog2(TIMEOUT + 1);
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(TIMEOUT - 1);

    fetch_state_t      r_state;
    logic [31:0]       r_pc;
    logic [31:0]       r_instr;
    logic              r_instr_valid;
    logic              r_imem_req;
    logic [WAIT_W-1:0] r_wait_cnt;
    logic [31:0]       r_retire_cnt;
    logic              r_fetch_err;

    logic [31:0]       w_pc_plus4;
    logic [31:0]       w_next_pc;
    logic              w_unused;

    assign w_pc_plus4 = r_pc + 32'd4;
    // Only the sign bits of the ALU result and rs feed the branch conditions
    assign w_unused   = ^{alu_result_i[30:0], rs_data_i[30:0]};

    branch_resolve u_branch_resolve (
        .i_pc_plus4    (w_pc_plus4),
        .i_instr_idx   (r_instr[25:0]),
        .i_branch      (branch_i),
        .i_jump        (jump_i),
        .i_branch_type (branch_type_i),
        .i_alu_zero    (alu_zero_i),
        .i_alu_neg     (alu_result_i[31]),
        .i_rs_neg      (rs_data_i[31]),
        .o_next_pc     (w_next_pc)
    );

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_state       <= ST_IDLE;
            r_pc          <= PC_RESET;
            r_instr       <= 32'd0;
            r_instr_valid <= 1'b0;
            r_imem_req    <= 1'b0;
            r_wait_cnt    <= '0;
            r_retire_cnt  <= 32'd0;
            r_fetch_err   <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    r_state    <= ST_FETCH;
                    r_imem_req <= 1'b1;
                    r_wait_cnt <= '0;
                end
                ST_FETCH: begin
                    if (imem_rvalid_i) begin
                        r_instr       <= imem_rdata_i;
                        r_instr_valid <= 1'b1;
                        r_imem_req    <= 1'b0;
                        r_state       <= ST_EXEC;
                    end else if (r_wait_cnt == WAIT_LAST) begin
                        r_wait_cnt  <= r_wait_cnt + WAIT_W'(1);
                        r_fetch_err <= 1'b1;
                        r_imem_req  <= 1'b0;
                        r_state     <= ST_HALT;
                    end else begin
                        r_wait_cnt <= r_wait_cnt + WAIT_W'(1);
                    end
                end
                ST_EXEC: begin
                    if (!stall_i) begin
                        r_pc          <= w_next_pc;
                        r_retire_cnt  <= r_retire_cnt + 32'd1;
                        r_instr_valid <= 1'b0;
                        r_imem_req    <= 1'b1;
                        r_wait_cnt    <= '0;
                        r_state       <= ST_FETCH;
                    end
                end
                ST_HALT: begin
                    r_imem_req    <= 1'b0;
                    r_instr_valid <= 1'b0;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign imem_req_o    = r_imem_req;
    assign imem_addr_o   = r_pc;
    assign pc_o          = r_pc;
    assign pc_plus4_o    = w_pc_plus4;
    assign instr_o       = r_instr;
    assign instr_valid_o = r_instr_valid;
    assign retire_cnt_o  = r_retire_cnt;
    assign fetch_err_o   = r_fetch_err;

endmodule
